// File: rtl/pwr_seq_pkg.sv
// Shared types and per-state output encodings for the domain power sequencer.
package pwr_seq_pkg;

    typedef enum logic [3:0] {
        ST_OFF,
        ST_PU_SWITCH,
        ST_PU_ISO,
        ST_PU_RST,
        ST_ON,
        ST_PD_CLK,
        ST_PD_ISO,
        ST_PD_RST,
        ST_PD_SWITCH
    } pwr_seq_state_e;

    // All fields are active-low controls toward the switch cells / domain wrapper.
    typedef struct packed {
        logic switch_n;
        logic iso_n;
        logic rst_n;
        logic clken_n;
    } pwr_ctrl_t;

    localparam pwr_ctrl_t CTRL_OFF       = 4'b1000;
    localparam pwr_ctrl_t CTRL_PU_SWITCH = 4'b0000;
    localparam pwr_ctrl_t CTRL_PU_ISO    = 4'b0100;
    localparam pwr_ctrl_t CTRL_PU_RST    = 4'b0110;
    localparam pwr_ctrl_t CTRL_ON        = 4'b0111;
    localparam pwr_ctrl_t CTRL_PD_CLK    = 4'b0110;
    localparam pwr_ctrl_t CTRL_PD_ISO    = 4'b0010;
    localparam pwr_ctrl_t CTRL_PD_RST    = 4'b0000;
    localparam pwr_ctrl_t CTRL_PD_SWITCH = 4'b1000;

    // Control word driven while in a given state.
    function automatic pwr_ctrl_t state_ctrl(input pwr_seq_state_e s);
        case (s)
            ST_OFF:       return CTRL_OFF;
            ST_PU_SWITCH: return CTRL_PU_SWITCH;
            ST_PU_ISO:    return CTRL_PU_ISO;
            ST_PU_RST:    return CTRL_PU_RST;
            ST_ON:        return CTRL_ON;
            ST_PD_CLK:    return CTRL_PD_CLK;
            ST_PD_ISO:    return CTRL_PD_ISO;
            ST_PD_RST:    return CTRL_PD_RST;
            ST_PD_SWITCH: return CTRL_PD_SWITCH;
            default:      return CTRL_OFF;
        endcase
    endfunction

    // States that wait on the switch acknowledge rather than a fixed step.
    function automatic logic is_switch_wait(input pwr_seq_state_e s);
        return (s == ST_PU_SWITCH) || (s == ST_PD_SWITCH);
    endfunction

endpackage

// File: rtl/ext_domain_power_sequencer_if.sv
// Request/acknowledge and domain control bundle between power manager, sequencer and switch cells.
interface ext_domain_power_sequencer_if;
    logic power_on_req_i;
    logic switch_ack_ni;
    logic switch_n_o;
    logic iso_n_o;
    logic domain_rst_no;
    logic clkgate_en_no;
    logic busy_o;
    logic powered_o;
    logic timeout_o;

    modport master (
        input  power_on_req_i,
        input  switch_ack_ni,
        output switch_n_o,
        output iso_n_o,
        output domain_rst_no,
        output clkgate_en_no,
        output busy_o,
        output powered_o,
        output timeout_o
    );

    modport slave (
        output power_on_req_i,
        output switch_ack_ni,
        input  switch_n_o,
        input  iso_n_o,
        input  domain_rst_no,
        input  clkgate_en_no,
        input  busy_o,
        input  powered_o,
        input  timeout_o
    );
endinterface

// File: rtl/pwr_ack_sync.sv
// N-stage synchronizer for the asynchronous switch acknowledge; resets to 1 ("not powered").
module pwr_ack_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input in at the low end.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    // Synchronizer flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/ext_domain_power_sequencer.sv
// Power-gating sequencer for one domain: switch, isolation, reset and clock gate in safe order.
module ext_domain_power_sequencer
    import pwr_seq_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 4,
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          RESET_ON    = 1'b1
) (
    input logic clk_i,
    input logic rst_ni,
    ext_domain_power_sequencer_if.master pwr_if
);
    localparam int unsigned CNT_SPAN = (STEP_CYCLES > ACK_TIMEOUT) ? STEP_CYCLES : ACK_TIMEOUT;
    localparam int unsigned CNT_W    = $clog2(CNT_SPAN + 1);
    localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LIMIT = CNT_W'(ACK_TIMEOUT);
    localparam bit               TIMEOUT_EN = (ACK_TIMEOUT != 0);
    localparam pwr_seq_state_e   RESET_STATE = RESET_ON ? ST_PU_SWITCH : ST_OFF;
    localparam pwr_ctrl_t        RESET_CTRL  = RESET_ON ? CTRL_PU_SWITCH : CTRL_OFF;

    pwr_seq_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pwr_ctrl_t        ctrl_q, ctrl_d;
    logic             busy_q, busy_d;
    logic             powered_q, powered_d;
    logic             timeout_q, timeout_d;
    logic             ack_s;

    pwr_ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pwr_if.switch_ack_ni),
        .q_o    (ack_s)
    );

    // Next state, shared step/wait counter, timeout flag and Moore output decode of the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_OFF:       if (pwr_if.power_on_req_i)  state_d = ST_PU_SWITCH;
            ST_PU_SWITCH: if (!ack_s)                 state_d = ST_PU_ISO;
            ST_PU_ISO:    if (cnt_q == '0)            state_d = ST_PU_RST;
            ST_PU_RST:    if (cnt_q == '0)            state_d = ST_ON;
            ST_ON:        if (!pwr_if.power_on_req_i) state_d = ST_PD_CLK;
            ST_PD_CLK:    if (cnt_q == '0)            state_d = ST_PD_ISO;
            ST_PD_ISO:    if (cnt_q == '0)            state_d = ST_PD_RST;
            ST_PD_RST:    if (cnt_q == '0)            state_d = ST_PD_SWITCH;
            ST_PD_SWITCH: if (ack_s)                  state_d = ST_OFF;
            default:                                  state_d = ST_OFF;
        endcase

        // Timed states count down from STEP_CYCLES-1; switch waits count up and saturate.
        if (state_d != state_q) begin
            cnt_d = is_switch_wait(state_d) ? '0 : STEP_LOAD;
        end else if (is_switch_wait(state_q)) begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // Sticky until the next switch-wait entry; a late ack still completes the sequence.
        if ((state_d != state_q) && is_switch_wait(state_d)) begin
            timeout_d = 1'b0;
        end else if (TIMEOUT_EN && is_switch_wait(state_q) && (state_d == state_q)
                     && (cnt_d == ACK_LIMIT)) begin
            timeout_d = 1'b1;
        end

        ctrl_d    = state_ctrl(state_d);
        busy_d    = !((state_d == ST_ON) || (state_d == ST_OFF));
        powered_d = (state_d == ST_ON);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RESET_STATE;
            cnt_q     <= '0;
            ctrl_q    <= RESET_CTRL;
            busy_q    <= RESET_ON;
            powered_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            busy_q    <= busy_d;
            powered_q <= powered_d;
            timeout_q <= timeout_d;
        end
    end

    assign pwr_if.switch_n_o    = ctrl_q.switch_n;
    assign pwr_if.iso_n_o       = ctrl_q.iso_n;
    assign pwr_if.domain_rst_no = ctrl_q.rst_n;
    assign pwr_if.clkgate_en_no = ctrl_q.clken_n;
    assign pwr_if.busy_o        = busy_q;
    assign pwr_if.powered_o     = powered_q;
    assign pwr_if.timeout_o     = timeout_q;
endmodule

// File: tb/tb_ext_domain_power_sequencer.sv
// Directed vector bench for ext_domain_power_sequencer (RESET_ON=1 and RESET_ON=0 instances).
module tb_ext_domain_power_sequencer;

    // Output word: {switch_n, iso_n, rst_n, clken_n, busy, powered, timeout}
    localparam logic [6:0] E_OFF   = 7'b1000_000;
    localparam logic [6:0] E_PUSW  = 7'b0000_100;
    localparam logic [6:0] E_PUISO = 7'b0100_100;
    localparam logic [6:0] E_PURST = 7'b0110_100;
    localparam logic [6:0] E_ON    = 7'b0111_010;
    localparam logic [6:0] E_PDCLK = 7'b0110_100;
    localparam logic [6:0] E_PDISO = 7'b0010_100;
    localparam logic [6:0] E_PDRST = 7'b0000_100;
    localparam logic [6:0] E_PDSW  = 7'b1000_100;
    localparam logic [6:0] TO      = 7'b0000_001;

    typedef struct {
        logic        req;
        logic        ack_n;
        int unsigned cycles;
        logic [6:0]  exp;
    } vec_t;

    logic clk;
    logic rst_na;
    logic rst_nb;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    ext_domain_power_sequencer_if a_if ();
    ext_domain_power_sequencer_if b_if ();

    ext_domain_power_sequencer #(
        .STEP_CYCLES(4), .ACK_TIMEOUT(32), .SYNC_STAGES(2), .RESET_ON(1'b1)
    ) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_na),
        .pwr_if (a_if)
    );

    ext_domain_power_sequencer #(
        .STEP_CYCLES(4), .ACK_TIMEOUT(32), .SYNC_STAGES(2), .RESET_ON(1'b0)
    ) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_nb),
        .pwr_if (b_if)
    );

    logic [6:0] a_out;
    logic [6:0] b_out;
    assign a_out = {a_if.switch_n_o, a_if.iso_n_o, a_if.domain_rst_no, a_if.clkgate_en_no,
                    a_if.busy_o, a_if.powered_o, a_if.timeout_o};
    assign b_out = {b_if.switch_n_o, b_if.iso_n_o, b_if.domain_rst_no, b_if.clkgate_en_no,
                    b_if.busy_o, b_if.powered_o, b_if.timeout_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (sw,iso,rst,clk,busy,pwr,to)", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Advance n clock cycles, ending on a falling edge (n=0 samples in place).
    task automatic step(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic add_vec(input logic req, input logic ack_n, input int unsigned cyc,
                           input logic [6:0] exp);
        vec_t v;
        v.req = req; v.ack_n = ack_n; v.cycles = cyc; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        int unsigned lat;
        int unsigned lat_cnt;
        int unsigned hold;
        int unsigned guard;

        n_checks = 0;
        n_fail   = 0;
        rst_na = 1'b0;
        rst_nb = 1'b0;
        a_if.power_on_req_i = 1'b1;
        a_if.switch_ack_ni  = 1'b1;
        b_if.power_on_req_i = 1'b0;
        b_if.switch_ack_ni  = 1'b1;

        // Power-up, power-down, glitches, timeout, mid-sequence req drop.
        add_vec(1, 1, 0,  E_PUSW);
        add_vec(1, 1, 14, E_PUSW);
        add_vec(1, 0, 2,  E_PUSW);
        add_vec(1, 0, 1,  E_PUISO);
        add_vec(1, 0, 3,  E_PUISO);
        add_vec(1, 0, 1,  E_PURST);
        add_vec(1, 0, 3,  E_PURST);
        add_vec(1, 0, 1,  E_ON);
        add_vec(1, 1, 5,  E_ON);
        add_vec(1, 0, 3,  E_ON);
        add_vec(0, 0, 1,  E_PDCLK);
        add_vec(0, 0, 3,  E_PDCLK);
        add_vec(0, 0, 1,  E_PDISO);
        add_vec(0, 0, 3,  E_PDISO);
        add_vec(0, 0, 1,  E_PDRST);
        add_vec(0, 0, 3,  E_PDRST);
        add_vec(0, 0, 1,  E_PDSW);
        add_vec(0, 0, 16, E_PDSW);
        add_vec(0, 1, 2,  E_PDSW);
        add_vec(0, 1, 1,  E_OFF);
        add_vec(0, 0, 6,  E_OFF);
        add_vec(0, 1, 3,  E_OFF);
        add_vec(1, 1, 1,  E_PUSW);
        add_vec(1, 1, 31, E_PUSW);
        add_vec(1, 1, 1,  E_PUSW | TO);
        add_vec(1, 1, 17, E_PUSW | TO);
        add_vec(1, 0, 2,  E_PUSW | TO);
        add_vec(1, 0, 1,  E_PUISO | TO);
        add_vec(1, 0, 8,  E_ON | TO);
        add_vec(0, 0, 1,  E_PDCLK | TO);
        add_vec(0, 0, 12, E_PDSW);
        add_vec(0, 1, 3,  E_OFF);
        add_vec(1, 1, 1,  E_PUSW);
        add_vec(1, 0, 3,  E_PUISO);
        add_vec(0, 0, 4,  E_PURST);
        add_vec(0, 0, 4,  E_ON);
        add_vec(0, 0, 1,  E_PDCLK);
        add_vec(0, 0, 12, E_PDSW);
        add_vec(0, 1, 3,  E_OFF);
        add_vec(1, 1, 1,  E_PUSW);
        add_vec(1, 0, 3,  E_PUISO);
        add_vec(1, 0, 8,  E_ON);
        add_vec(0, 0, 1,  E_PDCLK);
        add_vec(0, 0, 8,  E_PDRST);

        // Values held during reset.
        step(3);
        check("reset_a", a_out, E_PUSW);
        check("reset_b", b_out, E_OFF);
        rst_na = 1'b1;
        rst_nb = 1'b1;

        foreach (vecs[i]) begin
            a_if.power_on_req_i = vecs[i].req;
            a_if.switch_ack_ni  = vecs[i].ack_n;
            step(vecs[i].cycles);
            check($sformatf("vec%0d", i), a_out, vecs[i].exp);
        end

        // Asynchronous reset while in PD_RST.
        #2 rst_na = 1'b0;
        #1 check("async_rst_a", a_out, E_PUSW);
        @(negedge clk);
        check("held_rst_a", a_out, E_PUSW);
        rst_na = 1'b1;

        // RESET_ON=0 instance: idles OFF, premature ack accepted, reset mid-sequence.
        check("b_idle_off", b_out, E_OFF);
        b_if.switch_ack_ni = 1'b0;
        step(4);
        check("b_off_ack_glitch", b_out, E_OFF);
        b_if.power_on_req_i = 1'b1;
        step(1);
        check("b_pu_switch", b_out, E_PUSW);
        step(1);
        check("b_premature_ack", b_out, E_PUISO);
        step(4);
        check("b_pu_rst", b_out, E_PURST);
        #2 rst_nb = 1'b0;
        #1 check("async_rst_b", b_out, E_OFF);
        b_if.power_on_req_i = 1'b0;
        @(negedge clk);
        rst_nb = 1'b1;
        step(6);
        check("b_stays_off", b_out, E_OFF);
        b_if.power_on_req_i = 1'b1;
        step(1);
        check("b_req_wakes", b_out, E_PUSW);

        // Random req levels with an ack responder of random latency; ordering invariants every cycle.
        lat_cnt = 0;
        lat = 0;
        for (int run = 0; run < 100; run++) begin
            a_if.power_on_req_i = 1'($urandom_range(0, 1));
            lat  = $urandom_range(0, 20);
            hold = $urandom_range(1, 60);
            for (int unsigned c = 0; c < hold; c++) begin
                step(1);
                check_bit("inv_iso_needs_power", a_if.iso_n_o & a_if.switch_n_o, 1'b0);
                check_bit("inv_clk_needs_iso_rst",
                          a_if.clkgate_en_no & ~(a_if.iso_n_o & a_if.domain_rst_no), 1'b0);
                if (a_if.switch_n_o != a_if.switch_ack_ni) begin
                    if (lat_cnt >= lat) begin
                        a_if.switch_ack_ni = a_if.switch_n_o;
                        lat_cnt = 0;
                    end else begin
                        lat_cnt++;
                    end
                end else begin
                    lat_cnt = 0;
                end
            end
        end

        // Drain to OFF within a bounded number of cycles.
        a_if.power_on_req_i = 1'b0;
        guard = 0;
        while ((a_if.busy_o || a_if.powered_o) && guard < 300) begin
            step(1);
            if (a_if.switch_n_o != a_if.switch_ack_ni) begin
                if (lat_cnt >= lat) begin
                    a_if.switch_ack_ni = a_if.switch_n_o;
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end
            guard++;
        end
        check_bit("rand_drain_in_time", guard < 300, 1'b1);
        check("rand_final_off", a_out, E_OFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ext_domain_power_sequencer.md
Name: ext_domain_power_sequencer

Overview:
Power-gating controller for one external (or internal) power domain; the initiator end of the switch/ack handshake whose responder is the switch cell.
Drives switch_n, isolation, domain reset and clock gate in a fixed safe order, and waits on the active-low switch acknowledge before proceeding.
Sits next to the power manager. One instance per domain, with outputs going to the switch cells and the domain wrapper.
Power requests are a level target. A sequence that has started always runs to completion.

Parameters:
STEP_CYCLES, 4, cycles each intermediate step (iso/rst/clk) is held before the next; must be >=1
ACK_TIMEOUT, 1024, cycles to wait for ack before flagging timeout_o; 0 disables the timeout
SYNC_STAGES, 2, flip-flop stages on switch_ack_ni; must be >=2
RESET_ON, 1, 1 = domain powers up automatically after reset; 0 = domain stays OFF

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset; asynchronous, active-low
power_on_req_i  in  1  target state: 1 = domain on, 0 = domain off
switch_ack_ni  in  1  switch-cell acknowledge, active-low (0 = switch closed / powered); asynchronous
switch_n_o  out  1  switch control, active-low (0 = power on)
iso_n_o  out  1  isolation, active-low (0 = outputs isolated)
domain_rst_no  out  1  domain reset, active-low
clkgate_en_no  out  1  clock enable, active-low gate (0 = clock gated)
busy_o  out  1  1 while in any state other than ON or OFF
powered_o  out  1  1 only in state ON
timeout_o  out  1  sticky ack-timeout flag; cleared on entry to the next PU_SWITCH or PD_SWITCH

Behaviour:
- All outputs are registered; each is a Moore decode of the next state, so an output changes on the same edge the state changes.
- Ack path:
  - switch_ack_ni passes through a SYNC_STAGES flop synchronizer; ack_s is the synchronizer output.
  - The synchronizer resets to 1, i.e. "not powered".
- Reset values: switch_n_o=!RESET_ON, iso_n_o=0, domain_rst_no=0, clkgate_en_no=0, powered_o=0, timeout_o=0, busy_o=RESET_ON.
- Reset state: PU_SWITCH if RESET_ON=1, else OFF.
- States and outputs, listed as switch_n / iso_n / rst_n / clken_n:
  - OFF 1/0/0/0
  - PU_SWITCH 0/0/0/0
  - PU_ISO 0/1/0/0
  - PU_RST 0/1/1/0
  - ON 0/1/1/1
  - PD_CLK 0/1/1/0
  - PD_ISO 0/0/1/0
  - PD_RST 0/0/0/0
  - PD_SWITCH 1/0/0/0
- Transitions:
  - OFF -> PU_SWITCH when power_on_req_i=1.
  - PU_SWITCH -> PU_ISO when ack_s=0.
  - PU_ISO -> PU_RST -> ON: each step after STEP_CYCLES cycles in the state.
  - ON -> PD_CLK when power_on_req_i=0.
  - PD_CLK -> PD_ISO -> PD_RST -> PD_SWITCH: each step after STEP_CYCLES cycles.
  - PD_SWITCH -> OFF when ack_s=1.
- Step counter: loaded with STEP_CYCLES-1 on entry to each timed state; the state advances when the counter is 0.
- Counter width: $clog2(max(STEP_CYCLES, ACK_TIMEOUT)+1). There is one shared counter.
- Switch-wait states (PU_SWITCH, PD_SWITCH):
  - The counter counts up from 0 and saturates.
  - When it reaches ACK_TIMEOUT (if nonzero), timeout_o is set to 1.
  - The FSM keeps waiting; there is no abort.
  - A late ack still completes the sequence. timeout_o stays 1 until the next switch-wait entry.
- power_on_req_i is sampled only in ON and OFF. Toggles during a sequence are ignored; the level is re-evaluated once the sequence lands in ON or OFF.
  - Example: req drops during PU_RST -> the sequence reaches ON, then goes to PD_CLK on the next cycle.
- Ack glitch: a premature ack_s=0 seen in PU_SWITCH is accepted. The ack is trusted; no debounce.
- Ack polarity in stable states:
  - In ON, ack_s=1 is ignored.
  - In OFF, ack_s=0 is ignored.
  - Neither case changes any output.
- rst_ni asserted mid-sequence: all outputs return to their reset values immediately (asynchronously).
- Up-latency, with ack latency La cycles after switch_n_o falls: powered_o=1 is reached La + SYNC_STAGES + 2*STEP_CYCLES + 1 (±1) cycles after the req edge is sampled.

Decomposition:
- Shared package pwr_seq_pkg holds:
  - the state enum pwr_seq_state_e (9 states);
  - a packed struct pwr_ctrl_t {switch_n, iso_n, rst_n, clken_n};
  - the per-state output constants.
- One sub-module: pwr_ack_sync, a parameterized N-stage synchronizer with a reset value of 1.

Test Plan:
1. RESET_ON=1, responder acks after 15 cycles, STEP_CYCLES=4 -> switch_n_o=0 from reset; iso_n_o rises SYNC_STAGES cycles after ack falls; rst_n and clken_n each follow 4 cycles later; powered_o=1.
2. From ON, power_on_req_i=0 -> clken_n falls first, then iso_n 4 cycles later, then rst_n 4 cycles later, then switch_n_o=1; ack=1 after 15+2 cycles -> OFF, busy_o=0.
3. power_on_req_i toggled 1->0 during PU_ISO -> sequence completes to ON (powered_o pulses ≥1 cycle), then full power-down follows without further stimulus.
4. ACK_TIMEOUT=32, responder never acks -> timeout_o=1 exactly 32 cycles after entering PU_SWITCH; ack at cycle 50 -> sequence completes; timeout_o clears on the next PD_SWITCH entry.
5. rst_ni pulsed low during PD_RST -> all outputs are at reset values within the same cycle; with RESET_ON=0 the block stays OFF until req=1.
6. Ordering check across 100 random req/ack-latency runs: isolation is never released while switch_n_o=1, and clken_n_o=1 only when iso_n_o=1 and domain_rst_no=1.
